// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: opcodes, FSM states and instruction layout.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        MUL  = 4'd2,
        DIV  = 4'd3,
        SLL  = 4'd4,
        SRL  = 4'd5,
        ROL  = 4'd6,
        ROR  = 4'd7,
        AND  = 4'd8,
        OR   = 4'd9,
        XOR  = 4'd10,
        NOR  = 4'd11,
        NAND = 4'd12,
        XNOR = 4'd13,
        GT   = 4'd14,
        EQ   = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } ctrl_state_e;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned OP_MSB     = 15;
    localparam int unsigned OP_LSB     = 12;
    localparam int unsigned RD_MSB     = 11;
    localparam int unsigned RD_LSB     = 8;
    localparam int unsigned RS_MSB     = 7;
    localparam int unsigned RS_LSB     = 4;
    localparam int unsigned RT_MSB     = 3;
    localparam int unsigned RT_LSB     = 0;

    // Field order matches the bit slices above, so a plain cast decodes an instruction.
    typedef struct packed {
        alu_op_e               op;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
    } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two operand read ports, a debug read port, one write port, R0 reads as zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned ALU_SIZE = 16,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [ALU_SIZE-1:0]   wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    output logic [ALU_SIZE-1:0]   rdata_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [ALU_SIZE-1:0]   rdata_b,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [ALU_SIZE-1:0]   dbg_data
);

    logic [ALU_SIZE-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = (raddr_a  == '0) ? '0 : regs[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : regs[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller: fetches operands, drives the external ALU and writes results back.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned ALU_SIZE = 16,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [ALU_SIZE-1:0]   ld_data,
    output logic [ALU_SIZE-1:0]   alu_in_a,
    output logic [ALU_SIZE-1:0]   alu_in_b,
    output logic [3:0]            alu_sel,
    input  logic [ALU_SIZE-1:0]   alu_out,
    input  logic                  carry_out,
    output logic                  done,
    output logic                  div0_err,
    output logic                  carry_flag,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [ALU_SIZE-1:0]   dbg_data
);

    ctrl_state_e           state;
    instr_t                cur;
    logic [ALU_SIZE-1:0]   result;
    logic                  carry_cap;
    logic                  div_zero;

    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [ALU_SIZE-1:0]   wdata;
    logic [ALU_SIZE-1:0]   rdata_a;
    logic [ALU_SIZE-1:0]   rdata_b;

    assign instr_ready = (state == IDLE) && !ld_valid;

    // Loads only land in IDLE; writebacks to R0 are dropped inside the register file.
    always_comb begin
        we    = 1'b0;
        waddr = ld_addr;
        wdata = ld_data;
        if (state == IDLE && ld_valid) begin
            we = 1'b1;
        end else if (state == WB && !div_zero) begin
            we    = 1'b1;
            waddr = cur.rd;
            wdata = result;
        end
    end

    alu_regfile #(
        .ALU_SIZE (ALU_SIZE),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (cur.rs),
        .rdata_a  (rdata_a),
        .raddr_b  (cur.rt),
        .rdata_b  (rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            result     <= '0;
            carry_cap  <= 1'b0;
            div_zero   <= 1'b0;
            alu_in_a   <= '0;
            alu_in_b   <= '0;
            alu_sel    <= '0;
            done       <= 1'b0;
            div0_err   <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            done     <= 1'b0;
            div0_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!ld_valid && instr_valid) begin
                        cur   <= instr_t'(instr);
                        state <= READ;
                    end
                end
                READ: begin
                    alu_in_a <= rdata_a;
                    alu_in_b <= rdata_b;
                    alu_sel  <= cur.op;
                    state    <= EXEC;
                end
                EXEC: begin
                    result    <= alu_out;
                    carry_cap <= carry_out;
                    div_zero  <= (cur.op == DIV) && (alu_in_b == '0);
                    // done/div0_err are registered so they are high exactly while in WB.
                    done      <= 1'b1;
                    div0_err  <= (cur.op == DIV) && (alu_in_b == '0);
                    state     <= WB;
                end
                WB: begin
                    if (cur.op == ADD) begin
                        carry_flag <= carry_cap;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and register-file model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        ld_valid = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] alu_in_a;
    logic [15:0] alu_in_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_out;
    logic        carry_out;
    logic        done;
    logic        div0_err;
    logic        carry_flag;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int tests = 0;
    int fails = 0;

    logic [15:0] model [16];
    logic        mcarry;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .ALU_SIZE (16),
        .NUM_REGS (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_in_a    (alu_in_a),
        .alu_in_b    (alu_in_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .carry_out   (carry_out),
        .done        (done),
        .div0_err    (div0_err),
        .carry_flag  (carry_flag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Combinational ALU seen by the DUT; shifts and rotates move by one bit.
    function automatic logic [16:0] alu_fn(input logic [3:0] s, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] r;
        logic        c;
        c = 1'b0;
        case (s)
            4'd0:  {c, r} = {1'b0, a} + {1'b0, b};
            4'd1:  r = a - b;
            4'd2:  r = a * b;
            4'd3:  r = (b == 16'd0) ? 16'hFFFF : a / b;
            4'd4:  r = a << 1;
            4'd5:  r = a >> 1;
            4'd6:  r = {a[14:0], a[15]};
            4'd7:  r = {a[0], a[15:1]};
            4'd8:  r = a & b;
            4'd9:  r = a | b;
            4'd10: r = a ^ b;
            4'd11: r = ~(a | b);
            4'd12: r = ~(a & b);
            4'd13: r = ~(a ^ b);
            4'd14: r = {15'd0, a > b};
            default: r = {15'd0, a == b};
        endcase
        return {c, r};
    endfunction

    assign {carry_out, alu_out} = alu_fn(alu_sel, alu_in_a, alu_in_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input logic [3:0] a);
        dbg_addr = a;
        #1;
        chk($sformatf("reg_r%0d", a), dbg_data, model[a]);
    endtask

    task automatic check_all();
        for (int i = 0; i < 16; i++) begin
            check_reg(4'(i));
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        #1;
        chk("ready_during_load", instr_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        if (a != 4'd0) model[a] = d;
    endtask

    // Expected outcome is computed up front from the architectural rules.
    task automatic issue(input logic [15:0] ins, input bit noise);
        int          cyc;
        logic [3:0]  op, rd, rs, rt;
        logic [16:0] r;
        bit          dz;
        op = ins[15:12];
        rd = ins[11:8];
        rs = ins[7:4];
        rt = ins[3:0];
        r  = alu_fn(op, model[rs], model[rt]);
        dz = (op == 4'd3) && (model[rt] == 16'd0);
        instr       = ins;
        instr_valid = 1'b1;
        ld_valid    = 1'b0;
        #1;
        chk("ready_idle", instr_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        chk("ready_busy", instr_ready, 1'b0);
        cyc = 1;
        while (!done && cyc < 10) begin
            if (noise) begin
                ld_valid = 1'($urandom_range(0, 1));
                ld_addr  = 4'($urandom);
                ld_data  = 16'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        ld_valid = 1'b0;
        chk("latency", cyc, 3);
        chk("div0_err", div0_err, dz);
        if (rd != 4'd0 && !dz) model[rd] = r[15:0];
        if (op == 4'd0) mcarry = r[16];
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("carry_flag", carry_flag, mcarry);
        check_reg(rd);
    endtask

    initial begin
        int n, k, cyc;
        int acc [2];
        for (int i = 0; i < 16; i++) model[i] = '0;
        mcarry = 1'b0;
        acc[0] = 0;
        acc[1] = 0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a", alu_in_a, 16'd0);
        chk("rst_b", alu_in_b, 16'd0);
        chk("rst_sel", alu_sel, 4'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_div0", div0_err, 1'b0);
        chk("rst_carry", carry_flag, 1'b0);
        check_all();

        load(4'd1, 16'h0005);
        load(4'd2, 16'h0003);
        issue(16'h0312, 1'b0);
        chk("add_r3_const", dbg_data, 16'h0008);

        load(4'd1, 16'hFFFF);
        load(4'd2, 16'h0001);
        issue(16'h0412, 1'b0);
        chk("add_carry_const", carry_flag, 1'b1);
        issue(16'h1512, 1'b0);
        chk("sub_r5_const", dbg_data, 16'hFFFE);
        chk("sub_keeps_carry", carry_flag, 1'b1);

        load(4'd1, 16'h0009);
        load(4'd7, 16'h1234);
        issue(16'h3716, 1'b0);
        chk("div0_keeps_r7", dbg_data, 16'h1234);

        issue(16'h0012, 1'b0);
        chk("r0_zero", dbg_data, 16'h0000);
        load(4'd0, 16'hBEEF);
        check_reg(4'd0);

        // Load and instruction together: load wins, instruction waits a cycle.
        ld_valid    = 1'b1;
        ld_addr     = 4'd9;
        ld_data     = 16'h00AA;
        instr_valid = 1'b1;
        instr       = 16'h0912;
        #1;
        chk("ready_ld_and_instr", instr_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        model[9] = 16'h00AA;
        check_reg(4'd9);
        issue(16'h0912, 1'b0);

        // Asynchronous reset while in EXEC.
        load(4'd1, 16'h1357);
        instr       = 16'h0A11;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("exec_a_loaded", alu_in_a, 16'h1357);
        rst = 1'b1;
        #1;
        chk("arst_a", alu_in_a, 16'd0);
        chk("arst_b", alu_in_b, 16'd0);
        chk("arst_sel", alu_sel, 4'd0);
        chk("arst_ready", instr_ready, 1'b1);
        for (int i = 0; i < 16; i++) model[i] = '0;
        mcarry = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_no_done", done, 1'b0);
        chk("arst_carry", carry_flag, 1'b0);
        check_all();
        load(4'd1, 16'h8001);
        issue(16'h6210, 1'b0);
        chk("rol_const", dbg_data, 16'h0003);

        // Back-to-back issue with instr_valid held high.
        load(4'd1, 16'h0010);
        load(4'd2, 16'h0020);
        instr       = 16'h0312;
        instr_valid = 1'b1;
        n = 0;
        k = 0;
        while (k < 2 && n < 30) begin
            #1;
            if (instr_ready) begin
                acc[k] = n;
                k++;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
            if (k == 1) instr = 16'hF833;
        end
        instr_valid = 1'b0;
        chk("b2b_accepts", k, 2);
        chk("b2b_gap", acc[1] - acc[0], 4);
        model[3] = 16'h0030;
        mcarry   = 1'b0;
        model[8] = 16'h0001;
        cyc = 1;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_latency", cyc, 3);
        @(negedge clk);
        check_reg(4'd8);
        check_reg(4'd3);
        chk("b2b_carry", carry_flag, mcarry);

        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) load(4'($urandom), 16'($urandom));
            issue(16'($urandom), 1'b1);
        end
        check_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
